// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbiter with optional locked bursts.
//
// A port is eligible when its request and enable are both high. In
// arbitration the search starts at a rotating pointer and wraps modulo
// N_PORTS. A granted port holding its lock input high keeps the grant for up
// to HOLD_MAX consecutive cycles. HOLD_MAX=1 disables locking.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        per-port request
//   i_en         per-port enable
//   i_lock       per-port burst request, sampled only from the granted port
//   o_grant      combinational grant, one-hot or all-zero
//   o_grant_vld  OR-reduction of o_grant
//   o_grant_id   binary index of the granted port, 0 when nothing is granted
//   o_locked     registered, high while the FSM is in HOLD
module rr_arbiter_n #(
    parameter  int N_PORTS  = 4,
    parameter  int HOLD_MAX = 4,
    localparam int ID_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_PORTS-1:0] i_req,
    input  logic [N_PORTS-1:0] i_en,
    input  logic [N_PORTS-1:0] i_lock,
    output logic [N_PORTS-1:0] o_grant,
    output logic               o_grant_vld,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_locked
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_locked;

    state_t             w_state_nxt;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [ID_W-1:0]    w_owner_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic [N_PORTS-1:0] w_elig;
    logic               w_pick_found;
    logic [ID_W-1:0]    w_pick_id;
    logic               w_hold_active;
    logic [N_PORTS-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;

    assign w_elig        = i_req & i_en;
    assign w_hold_active = (r_state == ST_HOLD) && w_elig[r_owner];
    assign w_cnt_inc     = r_cnt + CNT_W'(1);

    // Rotating priority search: first eligible port at ptr, ptr+1, ... (mod N).
    always_comb begin
        int unsigned     v_idx;
        logic [ID_W-1:0] v_id;
        w_pick_found = 1'b0;
        w_pick_id    = {ID_W{1'b0}};
        v_idx        = 32'd0;
        v_id         = {ID_W{1'b0}};
        for (int k = 0; k < N_PORTS; k++) begin
            v_idx = (32'(r_ptr) + 32'(k)) % 32'(N_PORTS);
            v_id  = v_idx[ID_W-1:0];
            if (!w_pick_found && w_elig[v_id]) begin
                w_pick_found = 1'b1;
                w_pick_id    = v_id;
            end else begin
                w_pick_found = w_pick_found;
            end
        end
    end

    // Grant selection: a live burst owner wins, otherwise the round-robin pick.
    always_comb begin
        w_grant    = {N_PORTS{1'b0}};
        w_grant_id = {ID_W{1'b0}};
        if (w_hold_active) begin
            w_grant    = N_PORTS'(1) << r_owner;
            w_grant_id = r_owner;
        end else if (w_pick_found) begin
            w_grant    = N_PORTS'(1) << w_pick_id;
            w_grant_id = w_pick_id;
        end else begin
            w_grant    = {N_PORTS{1'b0}};
            w_grant_id = {ID_W{1'b0}};
        end
    end

    // Outputs are forced to zero during reset even though they are combinational.
    assign o_grant     = i_rst ? {N_PORTS{1'b0}} : w_grant;
    assign o_grant_vld = |o_grant;
    assign o_grant_id  = i_rst ? {ID_W{1'b0}} : w_grant_id;
    assign o_locked    = r_locked;

    // Next-state logic for the ARB/HOLD FSM, pointer, owner and burst counter.
    always_comb begin
        w_state_nxt = ST_ARB;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (w_hold_active) begin
            // Pointer is frozen during a burst; it already points past the owner.
            w_cnt_nxt = w_cnt_inc;
            if (!i_lock[r_owner] || (w_cnt_inc == CNT_W'(HOLD_MAX))) begin
                w_state_nxt = ST_ARB;
            end else begin
                w_state_nxt = ST_HOLD;
            end
        end else if (w_pick_found) begin
            if (w_pick_id == ID_W'(N_PORTS - 1)) begin
                w_ptr_nxt = {ID_W{1'b0}};
            end else begin
                w_ptr_nxt = w_pick_id + ID_W'(1);
            end
            if (i_lock[w_pick_id] && (HOLD_MAX > 1)) begin
                w_state_nxt = ST_HOLD;
                w_owner_nxt = w_pick_id;
                w_cnt_nxt   = CNT_W'(1);
            end else begin
                w_state_nxt = ST_ARB;
            end
        end else begin
            w_state_nxt = ST_ARB;
        end
    end

    // State registers; reset aborts any burst immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_ARB;
            r_ptr    <= {ID_W{1'b0}};
            r_owner  <= {ID_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_locked <= (w_state_nxt == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Testbench for rr_arbiter_n: table-driven cycle vectors on a 4-port,
// HOLD_MAX=4 instance, plus hand-written sequences for asynchronous reset
// mid-burst and for a 3-port instance with locking disabled.
module tb_rr_arbiter_n;

    logic       clk;
    logic       rst;
    logic [3:0] req, en, lock;
    logic [3:0] grant;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       locked;

    logic [2:0] req1, en1, lock1;
    logic [2:0] grant1;
    logic       grant_vld1;
    logic [1:0] grant_id1;
    logic       locked1;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter_n #(.N_PORTS(4), .HOLD_MAX(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_en(en), .i_lock(lock),
        .o_grant(grant), .o_grant_vld(grant_vld), .o_grant_id(grant_id),
        .o_locked(locked)
    );

    rr_arbiter_n #(.N_PORTS(3), .HOLD_MAX(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_en(en1), .i_lock(lock1),
        .o_grant(grant1), .o_grant_vld(grant_vld1), .o_grant_id(grant_id1),
        .o_locked(locked1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] en;
        logic [3:0] lock;
        logic [3:0] g;
        logic [1:0] id;
        logic       lk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] e,
                                input logic [3:0] l, input logic [3:0] g,
                                input logic [1:0] id, input logic lk);
        vec_t v;
        v.rst = r; v.req = rq; v.en = e; v.lock = l; v.g = g; v.id = id; v.lk = lk;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic lk);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " grant_vld"}, 32'(grant_vld), 32'(|g));
        check({tag, " grant_id"}, 32'(grant_id), 32'(id));
        check({tag, " locked"}, 32'(locked), 32'(lk));
    endtask

    initial begin
        // rst, req, en, lock -> expected grant, grant_id, locked
        // reset state
        add(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
        // plain rotation 0,1,2,3,0
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
        // sparse requests 1,3,1,3 without idle
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1010, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b1010, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
        add(1'b0, 4'b1010, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b1010, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
        // port 2 burst capped at 4 grants
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0010, 2'd1, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0001, 2'd0, 1'b0);
        // owner 0 drops its request in the 2nd burst cycle
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b0011, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b0);
        add(1'b0, 4'b0010, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b0010, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b0);
        // only port 2 enabled; locks on other ports ignored
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b1111, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 4'b1111, 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0);
        // owner disabled mid-burst hands over to a locking port 1, then release
        add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0011, 4'b0001, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1110, 4'b0011, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b1111, 4'b1110, 4'b0011, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b1111, 4'b1110, 4'b0001, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 4'b1111, 4'b1110, 4'b0001, 4'b0100, 2'd2, 1'b0);
        // idle cycle keeps the pointer, then wrap-around from port 3 to 0
        add(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);

        rst  = 1'b1;
        req  = 4'b0000; en  = 4'b0000; lock  = 4'b0000;
        req1 = 3'b000;  en1 = 3'b000;  lock1 = 3'b000;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; req = tbl[i].req; en = tbl[i].en; lock = tbl[i].lock;
            #1;
            check_main($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].lk);
        end

        // Asynchronous reset in the middle of a port-2 burst.
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b1111; en = 4'b1111; lock = 4'b0100;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_main($sformatf("burst c%0d", c), 4'b0001 << ((c < 3) ? c : 2),
                       (c < 3) ? 2'(c) : 2'd2, (c == 3) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_main("rst mid-burst", 4'b0000, 2'd0, 1'b0);
        @(posedge clk); #1;
        check_main("rst held", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; lock = 4'b0000;
        #1;
        check_main("after rst", 4'b0001, 2'd0, 1'b0);

        // 3-port instance with locking disabled: wraps 0,1,2,0 and never locks.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req1 = 3'b111; en1 = 3'b111; lock1 = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("n3 c%0d grant", c), 32'(grant1), 32'(3'b001 << (c % 3)));
            check($sformatf("n3 c%0d grant_id", c), 32'(grant_id1), 32'(c % 3));
            check($sformatf("n3 c%0d locked", c), 32'(locked1), 32'd0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
